// File: rtl/decode_copy_if.sv
//==============================================================================
// Module      : decode_copy_if
// Description : Bundle of the decode_copy side-band buses: token input
//               (literal / match command), history RAM read and write ports,
//               output FIFO strobe, and stream status.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface decode_copy_if #(
  parameter int AW = 11,
  parameter int LW = 12
);
  // stream control
  logic          clear;
  // literal path from the token parser
  logic          lit_valid;
  logic [7:0]    lit_data;
  logic          lit_ack;
  // match command path from the token parser
  logic          cmd_valid;
  logic [AW-1:0] cmd_offset;
  logic [LW-1:0] cmd_len;
  logic          cmd_ack;
  // history RAM read port (1-cycle registered read data)
  logic          hist_rd;
  logic [AW-1:0] hist_raddr;
  logic [7:0]    hist_rdata;
  // history RAM write port
  logic          hist_we;
  logic [AW-1:0] hist_waddr;
  logic [7:0]    hist_wdata;
  // output FIFO side
  logic          fo_full;
  logic [7:0]    out_data;
  logic          out_valid;
  // status
  logic          busy;
  logic          err;

  // Copy engine view
  modport slave (
    input  clear,
    input  lit_valid, lit_data,
    output lit_ack,
    input  cmd_valid, cmd_offset, cmd_len,
    output cmd_ack,
    output hist_rd, hist_raddr,
    input  hist_rdata,
    output hist_we, hist_waddr, hist_wdata,
    input  fo_full,
    output out_data, out_valid,
    output busy, err
  );

  // Environment view: parser, RAM and output FIFO
  modport master (
    output clear,
    output lit_valid, lit_data,
    input  lit_ack,
    output cmd_valid, cmd_offset, cmd_len,
    input  cmd_ack,
    input  hist_rd, hist_raddr,
    output hist_rdata,
    input  hist_we, hist_waddr, hist_wdata,
    output fo_full,
    input  out_data, out_valid,
    input  busy, err
  );
endinterface

`default_nettype wire

// File: rtl/decode_copy.sv
//==============================================================================
// Module      : decode_copy
// Description : LZS back-reference copy engine and history-window controller.
//               Accepts literals and (offset, length) match commands, emits
//               every produced byte to the output FIFO and into a 2^AW-byte
//               ring history held in an external dual-port RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module decode_copy #(
  parameter int AW = 11,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rst,
  decode_copy_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COPY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0]   c_FILL_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   c_FILL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] c_LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_wptr;      // next history write address
  logic [AW-1:0] r_rptr;      // next history read address during a copy
  logic [AW:0]   r_fill;      // valid history bytes, saturating at 2^AW
  logic [7:0]    r_last;      // most recently emitted byte
  logic [LW-1:0] r_remain;    // copy bytes still to be issued
  logic          r_rep;       // offset==1 copy: replay r_last, no RAM reads
  logic          r_inflight;  // a RAM read was issued last cycle
  logic          r_err;
  logic [7:0]    r_out_data;
  logic          r_out_valid;

  logic          w_lit_take;
  logic          w_cmd_take;
  logic          w_cmd_bad;
  logic          w_cmd_ok;
  logic          w_issue;
  logic          w_rd;
  logic          w_rep_emit;
  logic          w_emit;
  logic [7:0]    w_byte;
  logic          w_clear_ok;

  // A command is illegal if it points at nothing or past the filled history.
  assign w_cmd_bad  = (bus.cmd_offset == '0) || ({1'b0, bus.cmd_offset} > r_fill);
  // Zero-length commands are silent no-ops, even with a bad offset.
  assign w_cmd_ok   = (bus.cmd_len != '0) && !w_cmd_bad;
  assign w_clear_ok = (r_state == S_IDLE) && bus.clear;

  // Next-state and token acceptance; clear takes the idle cycle for itself.
  always_comb begin
    w_state_nxt = r_state;
    w_lit_take  = 1'b0;
    w_cmd_take  = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.clear) begin
          if (bus.lit_valid && !bus.fo_full) begin
            w_lit_take = 1'b1;
          end else if (bus.cmd_valid) begin
            w_cmd_take = 1'b1;
            if (w_cmd_ok) begin
              w_state_nxt = S_COPY;
            end
          end
        end
      end
      S_COPY: begin
        if (r_remain != '0) begin
          if (!bus.fo_full) begin
            w_issue = 1'b1;
            if (r_remain == c_LEN_ONE) begin
              // replay copies emit in the issue cycle; RAM copies need a drain
              w_state_nxt = r_rep ? S_IDLE : S_DRAIN;
            end
          end
        end else begin
          w_state_nxt = r_inflight ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Emit sources are mutually exclusive: literals only in idle, read data
  // only while copying/draining, replay only in an offset==1 copy.
  assign w_rd       = w_issue && !r_rep;
  assign w_rep_emit = w_issue && r_rep;
  assign w_emit     = w_lit_take || r_inflight || w_rep_emit;
  assign w_byte     = w_lit_take ? bus.lit_data :
                      r_inflight ? bus.hist_rdata : r_last;

  // Combinational strobes are forced low while reset is held.
  assign bus.lit_ack    = w_lit_take && !rst;
  assign bus.cmd_ack    = w_cmd_take && !rst;
  assign bus.hist_rd    = w_rd && !rst;
  assign bus.hist_raddr = r_rptr;
  assign bus.hist_we    = w_emit && !rst;
  assign bus.hist_waddr = r_wptr;
  assign bus.hist_wdata = (w_emit && !rst) ? w_byte : 8'h00;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err        = r_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: each emitted byte appears on the FIFO port one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= w_byte;
      end
    end
  end

  // History window: write pointer, fill level and last byte track every emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_fill <= '0;
      r_last <= 8'h00;
    end else if (w_clear_ok) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (w_emit) begin
      r_wptr <= r_wptr + c_ADDR_ONE;
      r_last <= w_byte;
      if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + c_FILL_ONE;
      end
    end
  end

  // Copy control: latch a command, then step the read pointer and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr     <= '0;
      r_remain   <= '0;
      r_rep      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_cmd_take) begin
        r_rptr   <= r_wptr - bus.cmd_offset;
        r_remain <= bus.cmd_len;
        r_rep    <= (bus.cmd_offset == c_ADDR_ONE);
      end else if (w_issue) begin
        r_remain <= r_remain - c_LEN_ONE;
        if (!r_rep) begin
          r_rptr <= r_rptr + c_ADDR_ONE;
        end
      end
    end
  end

  // Sticky error flag for illegal offsets, cleared only by a new stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_clear_ok) begin
      r_err <= 1'b0;
    end else if (w_cmd_take && (bus.cmd_len != '0) && w_cmd_bad) begin
      r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_copy.sv
//==============================================================================
// Module      : tb_decode_copy
// Description : Directed self-checking bench for decode_copy with a
//               behavioural 1-cycle-latency history RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_decode_copy;

  localparam int AW = 11;
  localparam int LW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_copy_if #(.AW(AW), .LW(LW)) u_bus ();

  decode_copy #(.AW(AW), .LW(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  // history RAM model: write-then-readable next cycle, registered read
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (u_bus.hist_we) mem[u_bus.hist_waddr] <= u_bus.hist_wdata;
    if (u_bus.hist_rd) u_bus.hist_rdata <= mem[u_bus.hist_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // activity logs, sampled mid-cycle
  int          wcyc[$];
  logic [10:0] wadr[$];
  logic [7:0]  wdat[$];
  int          rcyc[$];
  logic [10:0] radr[$];
  int          ocyc[$];
  logic [7:0]  odat[$];
  int          rd_full = 0;
  logic [7:0]  eq[$];

  always @(negedge clk) begin
    if (u_bus.hist_we) begin
      wcyc.push_back(cyc); wadr.push_back(u_bus.hist_waddr); wdat.push_back(u_bus.hist_wdata);
    end
    if (u_bus.hist_rd) begin
      rcyc.push_back(cyc); radr.push_back(u_bus.hist_raddr);
      if (u_bus.fo_full) rd_full = rd_full + 1;
    end
    if (u_bus.out_valid) begin
      ocyc.push_back(cyc); odat.push_back(u_bus.out_data);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fpat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    wcyc.delete(); wadr.delete(); wdat.delete();
    rcyc.delete(); radr.delete(); ocyc.delete(); odat.delete();
    rd_full = 0;
  endtask

  task automatic send_lit(input logic [7:0] b);
    bit ok = 0;
    u_bus.lit_valid = 1'b1; u_bus.lit_data = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u_bus.lit_ack) begin ok = 1; break; end
    end
    if (!ok) check("lit_ack_timeout", 0, 1);
    sync();
    u_bus.lit_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [10:0] off, input logic [11:0] len);
    bit ok = 0;
    u_bus.cmd_valid = 1'b1; u_bus.cmd_offset = off; u_bus.cmd_len = len;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u_bus.cmd_ack) begin ok = 1; break; end
    end
    if (!ok) check("cmd_ack_timeout", 0, 1);
    sync();
    u_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!u_bus.busy) begin ok = 1; break; end
    end
    if (!ok) check("busy_timeout", 0, 1);
    sync(); sync();
  endtask

  task automatic pulse_clear();
    u_bus.clear = 1'b1;
    sync();
    u_bus.clear = 1'b0;
  endtask

  // compare logged writes and outputs against eq[], writes starting at base
  task automatic check_stream(input string tag, input int base);
    check({tag, "_nwr"}, wadr.size(), eq.size());
    check({tag, "_nout"}, odat.size(), eq.size());
    for (int i = 0; i < eq.size(); i++) begin
      if (i < wadr.size()) begin
        check($sformatf("%s_waddr%0d", tag, i), 32'(wadr[i]), 32'((base + i) % (1 << AW)));
        check($sformatf("%s_wdata%0d", tag, i), 32'(wdat[i]), 32'(eq[i]));
      end
      if (i < odat.size() && i < wcyc.size()) begin
        check($sformatf("%s_odata%0d", tag, i), 32'(odat[i]), 32'(eq[i]));
        check($sformatf("%s_olat%0d", tag, i), ocyc[i], wcyc[i] + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cyc;
    rst = 1'b1;
    u_bus.clear = 1'b0; u_bus.fo_full = 1'b0;
    u_bus.lit_valid = 1'b1; u_bus.lit_data = 8'hEE;
    u_bus.cmd_valid = 1'b1; u_bus.cmd_offset = 11'd1; u_bus.cmd_len = 12'd1;
    u_bus.hist_rdata = 8'h00;

    // ---------------- reset state, strobes gated by reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", u_bus.out_valid, 0);
    check("rst_busy", u_bus.busy, 0);
    check("rst_err", u_bus.err, 0);
    check("rst_hist_we", u_bus.hist_we, 0);
    check("rst_hist_rd", u_bus.hist_rd, 0);
    check("rst_lit_ack", u_bus.lit_ack, 0);
    check("rst_cmd_ack", u_bus.cmd_ack, 0);
    check("rst_no_writes", wadr.size(), 0);
    sync();
    u_bus.lit_valid = 1'b0; u_bus.cmd_valid = 1'b0;
    rst = 1'b0;
    sync();
    clear_logs();

    // ---------------- literals A B C
    send_lit(8'h41); send_lit(8'h42); send_lit(8'h43);
    sync(); sync();
    eq = {8'h41, 8'h42, 8'h43};
    check_stream("lit", 0);

    // ---------------- overlapping copy offset 3 len 5
    clear_logs();
    send_cmd(11'd3, 12'd5);
    idle_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!u_bus.busy) begin idle_cyc = cyc; break; end
    end
    sync(); sync();
    eq = {8'h41, 8'h42, 8'h43, 8'h41, 8'h42};
    check_stream("copy3", 3);
    check("copy3_nrd", radr.size(), 5);
    for (int i = 0; i < radr.size() && i < 5; i++) begin
      check($sformatf("copy3_raddr%0d", i), 32'(radr[i]), i);
      check($sformatf("copy3_rcyc%0d", i), rcyc[i], rcyc[0] + i);
    end
    if (wcyc.size() == 5) check("copy3_busy_drop", idle_cyc, wcyc[4] + 1);
    check("copy3_err", u_bus.err, 0);

    // ---------------- replay copy offset 1 len 4 (literal lands at wptr=8)
    clear_logs();
    send_lit(8'h5A);
    send_cmd(11'd1, 12'd4);
    wait_idle();
    eq = {8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    check_stream("rep1", 8);
    check("rep1_no_reads", radr.size(), 0);

    // ---------------- copy with fo_full stall for 3 cycles
    clear_logs();
    send_lit(8'h10); send_lit(8'h11); send_lit(8'h12);
    send_cmd(11'd3, 12'd6);
    sync();
    u_bus.fo_full = 1'b1;
    repeat (3) @(posedge clk);
    #1 u_bus.fo_full = 1'b0;
    wait_idle();
    eq = {8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h12};
    check_stream("stall", 13);
    check("stall_rd_while_full", rd_full, 0);
    check("stall_nrd", radr.size(), 6);
    for (int i = 0; i < radr.size() && i < 6; i++)
      check($sformatf("stall_raddr%0d", i), 32'(radr[i]), 13 + i);
    if (rcyc.size() == 6) check("stall_rd_span", rcyc[5] - rcyc[0], 8);

    // ---------------- priority, illegal offset, clear
    clear_logs();
    pulse_clear();
    send_lit(8'h61);
    u_bus.lit_valid = 1'b1; u_bus.lit_data = 8'h62;
    u_bus.cmd_valid = 1'b1; u_bus.cmd_offset = 11'd5; u_bus.cmd_len = 12'd3;
    @(negedge clk);
    check("prio_lit_ack", u_bus.lit_ack, 1);
    check("prio_cmd_ack", u_bus.cmd_ack, 0);
    sync();
    u_bus.lit_valid = 1'b0;
    @(negedge clk);
    check("bad_cmd_ack", u_bus.cmd_ack, 1);
    sync();
    u_bus.cmd_valid = 1'b0;
    repeat (3) sync();
    check("bad_err", u_bus.err, 1);
    check("bad_busy", u_bus.busy, 0);
    eq = {8'h61, 8'h62};
    check_stream("bad", 0);

    clear_logs();
    pulse_clear();
    @(negedge clk);
    check("clr_err", u_bus.err, 0);
    sync();
    send_lit(8'h70);
    send_cmd(11'd1, 12'd0);
    @(negedge clk);
    check("len0_err", u_bus.err, 0);
    check("len0_busy", u_bus.busy, 0);
    sync();
    send_cmd(11'd2, 12'd1);
    repeat (3) sync();
    check("clr_fill_err", u_bus.err, 1);
    eq = {8'h70};
    check_stream("clr", 0);

    // ---------------- pointer wrap
    pulse_clear();
    for (int i = 0; i < 2046; i++) send_lit(fpat(i));
    sync(); sync();
    clear_logs();
    send_cmd(11'd2, 12'd4);
    wait_idle();
    eq = {fpat(2044), fpat(2045), fpat(2044), fpat(2045)};
    check_stream("wrap", 2046);
    check("wrap_nrd", radr.size(), 4);
    for (int i = 0; i < radr.size() && i < 4; i++)
      check($sformatf("wrap_raddr%0d", i), 32'(radr[i]), 2044 + i);

    clear_logs();
    send_cmd(11'd2047, 12'd3);
    wait_idle();
    eq = {fpat(3), fpat(4), fpat(5)};
    check_stream("far", 2);
    check("far_err", u_bus.err, 0);

    // ---------------- reset mid-copy
    clear_logs();
    send_cmd(11'd2, 12'd20);
    repeat (3) sync();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", u_bus.out_valid, 0);
    check("mid_rst_hist_we", u_bus.hist_we, 0);
    check("mid_rst_hist_rd", u_bus.hist_rd, 0);
    check("mid_rst_busy", u_bus.busy, 0);
    clear_logs();
    repeat (3) @(negedge clk);
    check("mid_rst_no_writes", wadr.size(), 0);
    sync();
    rst = 1'b0;
    sync();
    clear_logs();
    send_lit(8'h99);
    sync(); sync();
    eq = {8'h99};
    check_stream("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
